// File: rtl/t05_cb_pkg.sv
// t05_cb_pkg: state encoding and tag helpers shared by
// the stack-based Huffman codebook generator.
package t05_cb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_RD,
    S_VISIT,
    S_EMIT,
    S_POP,
    S_DONE,
    S_ERROR
  } cb_state_t;

  // NULL child tag: top two bits set, rest zero
  function automatic logic [31:0] tag_null(input int char_w);
    return 32'h3 << (char_w - 1);
  endfunction

  // A tag whose top bit is clear carries a char
  function automatic logic tag_is_char(
    input logic [31:0] tag,
    input int          char_w
  );
    return !tag[char_w];
  endfunction

  // Child node index of a sum tag
  function automatic logic [31:0] tag_idx(
    input logic [31:0] tag,
    input int          idx_w
  );
    return tag & ((32'h1 << idx_w) - 32'h1);
  endfunction

endpackage

// File: rtl/t05_cb_stack_synth_if.sv
// t05_cb_stack_synth_if: node-read request/response and
// codeword valid/ready stream of the codebook generator.
interface t05_cb_stack_synth_if #(
  parameter int CHAR_W       = 8,
  parameter int ADDR_W       = 8,
  parameter int MAX_CODE_LEN = 16
) ();
  localparam int TAG_W = CHAR_W + 1;
  localparam int LEN_W = $clog2(MAX_CODE_LEN + 1);

  logic                    rd_req;
  logic [ADDR_W-1:0]       rd_addr;
  logic                    rd_valid;
  logic [2*TAG_W-1:0]      rd_data;
  logic                    cw_valid;
  logic                    cw_ready;
  logic [CHAR_W-1:0]       cw_char;
  logic [MAX_CODE_LEN-1:0] cw_code;
  logic [LEN_W-1:0]        cw_len;

  modport master (
    output rd_req, rd_addr,
    input  rd_valid, rd_data,
    output cw_valid, cw_char, cw_code, cw_len,
    input  cw_ready
  );

  modport slave (
    input  rd_req, rd_addr,
    output rd_valid, rd_data,
    input  cw_valid, cw_char, cw_code, cw_len,
    output cw_ready
  );
endinterface

// File: rtl/t05_cb_lifo.sv
// t05_cb_lifo: synchronous stack of pending right branches;
// rdata always shows the top entry.
module t05_cb_lifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] top;

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign top   = cnt_q - CNT_W'(1);
  assign rdata = mem_q[top[PTR_W-1:0]];

  // clear beats push beats pop; overflow/underflow ignored
  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (push && !full) begin
      mem_d[cnt_q[PTR_W-1:0]] = wdata;
      cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && !empty) begin
      cnt_d = top;
    end
  end

  // storage and depth, frozen while en is low
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      mem_q <= '{default: '0};
    end else if (en) begin
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/t05_cb_stack_synth.sv
// t05_cb_stack_synth: depth-first Huffman tree walk that
// streams {char, code, len} per leaf, pre-order left-first.
module t05_cb_stack_synth
  import t05_cb_pkg::*;
#(
  parameter int CHAR_W       = 8,
  parameter int NODE_IDX_W   = 7,
  parameter int ADDR_W       = 8,
  parameter int ADDR_SHIFT   = 1,
  parameter int MAX_CODE_LEN = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NODE_IDX_W-1:0] root_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [CHAR_W:0]       num_codes,
  t05_cb_stack_synth_if.master  cb
);
  localparam int TAG_W = CHAR_W + 1;
  localparam int LEN_W = $clog2(MAX_CODE_LEN + 1);
  localparam int ENT_W = TAG_W + MAX_CODE_LEN + LEN_W;
  localparam logic [TAG_W-1:0] NULL_TAG =
    TAG_W'(tag_null(CHAR_W));
  localparam logic [LEN_W:0] MAX_LEN =
    (LEN_W+1)'(MAX_CODE_LEN);

  cb_state_t state_q, state_d;

  logic [NODE_IDX_W-1:0]   node_q, node_d;
  logic [MAX_CODE_LEN-1:0] code_q, code_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [TAG_W-1:0]        ltag_q, ltag_d;
  logic [TAG_W-1:0]        rtag_q, rtag_d;
  logic [CHAR_W-1:0]       cw_char_q, cw_char_d;
  logic [MAX_CODE_LEN-1:0] cw_code_q, cw_code_d;
  logic [LEN_W-1:0]        cw_len_q, cw_len_d;
  logic [CHAR_W:0]         num_q, num_d;

  logic             st_push, st_pop, st_clr;
  logic             st_full, st_empty;
  logic [ENT_W-1:0] st_wdata, st_rdata;

  logic [LEN_W:0]          nlen;
  logic [MAX_CODE_LEN-1:0] code_sh;
  logic                    l_null, r_null, l_char;
  logic [TAG_W-1:0]        p_tag;
  logic [MAX_CODE_LEN-1:0] p_code;
  logic [LEN_W-1:0]        p_len;
  logic                    p_char;

  assign nlen    = {1'b0, len_q} + (LEN_W+1)'(1);
  assign code_sh = code_q << 1;
  assign l_null  = (ltag_q == NULL_TAG);
  assign r_null  = (rtag_q == NULL_TAG);
  assign l_char  = tag_is_char(32'(ltag_q), CHAR_W);

  assign p_tag  = st_rdata[ENT_W-1 -: TAG_W];
  assign p_code = st_rdata[LEN_W +: MAX_CODE_LEN];
  assign p_len  = st_rdata[LEN_W-1:0];
  assign p_char = tag_is_char(32'(p_tag), CHAR_W);

  assign st_wdata = {rtag_q, code_sh | MAX_CODE_LEN'(1),
                     nlen[LEN_W-1:0]};

  t05_cb_lifo #(
    .W    (ENT_W),
    .DEPTH(MAX_CODE_LEN)
  ) u_lifo (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (st_clr),
    .push (st_push),
    .pop  (st_pop),
    .wdata(st_wdata),
    .rdata(st_rdata),
    .full (st_full),
    .empty(st_empty)
  );

  assign cb.rd_req   = (state_q inside {S_FETCH, S_WAIT_RD});
  assign cb.rd_addr  = cb.rd_req ?
    ADDR_W'(ADDR_W'(node_q) << ADDR_SHIFT) : '0;
  assign cb.cw_valid = (state_q == S_EMIT);
  assign cb.cw_char  = cw_char_q;
  assign cb.cw_code  = cw_code_q;
  assign cb.cw_len   = cw_len_q;

  assign busy  = !(state_q inside {S_IDLE, S_DONE, S_ERROR});
  assign done  = (state_q == S_DONE);
  assign error = (state_q == S_ERROR);
  assign num_codes = num_q;

  // traversal next-state, stack control and codeword load
  always_comb begin
    state_d   = state_q;
    node_d    = node_q;
    code_d    = code_q;
    len_d     = len_q;
    ltag_d    = ltag_q;
    rtag_d    = rtag_q;
    cw_char_d = cw_char_q;
    cw_code_d = cw_code_q;
    cw_len_d  = cw_len_q;
    num_d     = num_q;
    st_push   = 1'b0;
    st_pop    = 1'b0;
    st_clr    = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      st_clr  = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            st_clr  = 1'b1;
            num_d   = '0;
            code_d  = '0;
            len_d   = '0;
            node_d  = root_idx;
            state_d = S_FETCH;
          end
        end
        S_FETCH: state_d = S_WAIT_RD;
        S_WAIT_RD: begin
          if (cb.rd_valid) begin
            ltag_d  = cb.rd_data[2*TAG_W-1:TAG_W];
            rtag_d  = cb.rd_data[TAG_W-1:0];
            state_d = S_VISIT;
          end
        end
        S_VISIT: begin
          if (nlen > MAX_LEN) begin
            state_d = S_ERROR;
          end else if (l_null && r_null) begin
            state_d = S_POP;
          end else if (!r_null && st_full) begin
            state_d = S_ERROR;
          end else begin
            st_push = !r_null;
            if (l_null) begin
              state_d = S_POP;
            end else if (!l_char) begin
              code_d  = code_sh;
              len_d   = nlen[LEN_W-1:0];
              node_d  = NODE_IDX_W'(tag_idx(32'(ltag_q),
                                            NODE_IDX_W));
              state_d = S_FETCH;
            end else begin
              cw_char_d = ltag_q[CHAR_W-1:0];
              cw_code_d = code_sh;
              cw_len_d  = nlen[LEN_W-1:0];
              state_d   = S_EMIT;
            end
          end
        end
        S_EMIT: begin
          if (cb.cw_ready) begin
            num_d   = num_q + (CHAR_W+1)'(1);
            state_d = S_POP;
          end
        end
        S_POP: begin
          if (st_empty) begin
            state_d = S_DONE;
          end else begin
            st_pop = 1'b1;
            if (p_char) begin
              cw_char_d = p_tag[CHAR_W-1:0];
              cw_code_d = p_code;
              cw_len_d  = p_len;
              state_d   = S_EMIT;
            end else begin
              code_d  = p_code;
              len_d   = p_len;
              node_d  = NODE_IDX_W'(tag_idx(32'(p_tag),
                                            NODE_IDX_W));
              state_d = S_FETCH;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // state and datapath registers, frozen while en is low
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      node_q    <= '0;
      code_q    <= '0;
      len_q     <= '0;
      ltag_q    <= '0;
      rtag_q    <= '0;
      cw_char_q <= '0;
      cw_code_q <= '0;
      cw_len_q  <= '0;
      num_q     <= '0;
    end else if (en) begin
      state_q   <= state_d;
      node_q    <= node_d;
      code_q    <= code_d;
      len_q     <= len_d;
      ltag_q    <= ltag_d;
      rtag_q    <= rtag_d;
      cw_char_q <= cw_char_d;
      cw_code_q <= cw_code_d;
      cw_len_q  <= cw_len_d;
      num_q     <= num_d;
    end
  end

endmodule

// File: tb/tb_t05_cb_stack_synth.sv
// tb_t05_cb_stack_synth: directed and random trees checked
// against a breadth-first walk sorted into pre-order.
module tb_t05_cb_stack_synth;
  localparam logic [8:0] NUL = 9'h180;

  typedef struct {
    logic [7:0]  ch;
    logic [15:0] code;
    int          len;
  } cw_t;

  typedef struct {
    logic [8:0]  tag;
    logic [15:0] code;
    int          len;
  } wk_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [6:0] root_idx = '0;
  logic       busy, done, error;
  logic [8:0] num_codes;

  t05_cb_stack_synth_if #(
    .CHAR_W(8), .ADDR_W(8), .MAX_CODE_LEN(16)
  ) bus ();

  t05_cb_stack_synth #(
    .CHAR_W(8), .NODE_IDX_W(7), .ADDR_W(8),
    .ADDR_SHIFT(1), .MAX_CODE_LEN(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .start    (start),
    .abort    (abort),
    .root_idx (root_idx),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .num_codes(num_codes),
    .cb       (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int fails = 0;
  logic [8:0] lmem [128];
  logic [8:0] rmem [128];
  cw_t got[$];
  cw_t expq[$];
  logic [7:0] reads[$];
  int lats[$];
  int rises, mode, stall_cnt, rd_cnt, rd_ai, cyc, rv_cyc;
  bit sram_on, req_prev, prev_valid, prev_hs;
  logic [7:0]  pchar;
  logic [15:0] pcode;
  logic [4:0]  plen;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned key(input cw_t c);
    return 32'(c.code) << (16 - c.len);
  endfunction

  // every leaf's code from a breadth-first walk, then ordered
  // by code as a bit string: that is pre-order left-first
  function automatic void build_exp(input logic [6:0] root);
    wk_t wq[$];
    wk_t w;
    cw_t c;
    int j;
    expq.delete();
    wq.push_back('{tag: 9'h100 | 9'(root), code: 16'h0, len: 0});
    while (wq.size() > 0) begin
      w = wq.pop_front();
      if (w.tag == NUL) continue;
      if (!w.tag[8]) begin
        expq.push_back('{ch: w.tag[7:0], code: w.code, len: w.len});
      end else begin
        wq.push_back('{tag: lmem[w.tag[6:0]],
                       code: w.code << 1, len: w.len + 1});
        wq.push_back('{tag: rmem[w.tag[6:0]],
                       code: (w.code << 1) | 16'h1, len: w.len + 1});
      end
    end
    for (int i = 1; i < expq.size(); i++) begin
      c = expq[i];
      j = i - 1;
      while (j >= 0 && key(expq[j]) > key(c)) begin
        expq[j+1] = expq[j];
        j--;
      end
      expq[j+1] = c;
    end
  endfunction

  task automatic gen_tree(output logic [6:0] root);
    logic [8:0] items[$];
    logic [8:0] a, b;
    int k, nxt, un, ix;
    k = $urandom_range(1, 10);
    nxt = 40;
    un = 0;
    root = '0;
    for (int i = 0; i < k; i++)
      items.push_back({1'b0, 8'($urandom_range(32, 126))});
    while (items.size() > 1 || nxt == 40) begin
      ix = $urandom_range(0, items.size() - 1);
      a = items[ix];
      items.delete(ix);
      if (items.size() == 0 ||
          (un < 3 && $urandom_range(0, 4) == 0)) begin
        un++;
        if ($urandom_range(0, 1) == 1) begin
          lmem[nxt] = a; rmem[nxt] = NUL;
        end else begin
          lmem[nxt] = NUL; rmem[nxt] = a;
        end
      end else begin
        ix = $urandom_range(0, items.size() - 1);
        b = items[ix];
        items.delete(ix);
        lmem[nxt] = a; rmem[nxt] = b;
      end
      items.push_back(9'h100 | 9'(nxt));
      root = 7'(nxt);
      nxt++;
    end
  endtask

  // one clock: consumer, stream monitor and SRAM responder
  task automatic step();
    case (mode)
      0: bus.cw_ready = 1'b1;
      1: begin
        if (bus.cw_valid) begin
          bus.cw_ready = (stall_cnt == 5);
          stall_cnt = (stall_cnt == 5) ? 0 : stall_cnt + 1;
        end else begin
          bus.cw_ready = 1'b0;
          stall_cnt = 0;
        end
      end
      2: bus.cw_ready = 1'($urandom_range(0, 1));
      default: bus.cw_ready = 1'b0;
    endcase
    if (bus.cw_valid && prev_valid && !prev_hs) begin
      chk("hold_char", 32'(bus.cw_char), 32'(pchar));
      chk("hold_code", 32'(bus.cw_code), 32'(pcode));
      chk("hold_len", 32'(bus.cw_len), 32'(plen));
    end
    if (bus.cw_valid && !prev_valid) begin
      rises++;
      lats.push_back(cyc - rv_cyc);
    end
    prev_hs = bus.cw_valid && bus.cw_ready && en;
    if (prev_hs)
      got.push_back('{ch: bus.cw_char, code: bus.cw_code,
                      len: int'(bus.cw_len)});
    prev_valid = bus.cw_valid;
    pchar = bus.cw_char;
    pcode = bus.cw_code;
    plen = bus.cw_len;
    if (sram_on) begin
      bus.rd_valid = 1'b0;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          bus.rd_valid = 1'b1;
          bus.rd_data = {lmem[rd_ai], rmem[rd_ai]};
          rv_cyc = cyc;
        end
      end
      if (bus.rd_req && !req_prev) begin
        rd_cnt = 2;
        rd_ai = int'(bus.rd_addr) >> 1;
        reads.push_back(bus.rd_addr);
      end
      req_prev = bus.rd_req;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic begin_run();
    got.delete();
    reads.delete();
    lats.delete();
    rises = 0;
    prev_valid = 0;
    prev_hs = 0;
    stall_cnt = 0;
    rd_cnt = 0;
    req_prev = 0;
  endtask

  task automatic do_start(input logic [6:0] r);
    root_idx = r;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_to_rd_req", 32'(bus.rd_req), 32'h1);
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    while (!(done || error) && n < budget) begin
      step();
      n++;
    end
    chk("end_reached", 32'(done || error), 32'h1);
  endtask

  task automatic wait_emit();
    int n = 0;
    while (!bus.cw_valid && n < 60) begin
      step();
      n++;
    end
    chk("reach_emit", 32'(bus.cw_valid), 32'h1);
  endtask

  task automatic check_run();
    chk("num_codes", 32'(num_codes), 32'(expq.size()));
    chk("emit_count", 32'(got.size()), 32'(expq.size()));
    chk("done", 32'(done), 32'h1);
    chk("error", 32'(error), 32'h0);
    for (int i = 0; i < got.size() && i < expq.size(); i++) begin
      chk($sformatf("cw%0d_char", i), 32'(got[i].ch), 32'(expq[i].ch));
      chk($sformatf("cw%0d_code", i), 32'(got[i].code),
          32'(expq[i].code));
      chk($sformatf("cw%0d_len", i), 32'(got[i].len), 32'(expq[i].len));
    end
  endtask

  task automatic check_zero(input string t);
    chk({t, "_rd_req"}, 32'(bus.rd_req), 32'h0);
    chk({t, "_rd_addr"}, 32'(bus.rd_addr), 32'h0);
    chk({t, "_cw_valid"}, 32'(bus.cw_valid), 32'h0);
    chk({t, "_cw_char"}, 32'(bus.cw_char), 32'h0);
    chk({t, "_cw_code"}, 32'(bus.cw_code), 32'h0);
    chk({t, "_cw_len"}, 32'(bus.cw_len), 32'h0);
    chk({t, "_busy"}, 32'(busy), 32'h0);
    chk({t, "_done"}, 32'(done), 32'h0);
    chk({t, "_error"}, 32'(error), 32'h0);
    chk({t, "_num"}, 32'(num_codes), 32'h0);
  endtask

  initial begin
    logic [6:0] r;
    bus.rd_valid = 1'b0;
    bus.rd_data = '0;
    bus.cw_ready = 1'b0;
    sram_on = 1;
    mode = 0;
    cyc = 0;
    rv_cyc = 0;
    begin_run();
    rst = 1'b0;
    en = 1'b1;
    repeat (3) step();
    check_zero("reset");
    rst = 1'b1;
    step();

    // basic three-leaf tree
    lmem[1] = 9'h041; rmem[1] = 9'h103;
    lmem[3] = 9'h042; rmem[3] = 9'h043;
    build_exp(1);
    begin_run();
    do_start(1);
    wait_end(300);
    check_run();
    chk("t1_reads", 32'(reads.size()), 32'h2);
    if (reads.size() == 2) begin
      chk("t1_addr0", 32'(reads[0]), 32'h02);
      chk("t1_addr1", 32'(reads[1]), 32'h06);
    end
    if (lats.size() > 0)
      chk("rdv_to_cwv", 32'(lats[0]), 32'h2);
    if (got.size() == 3) begin
      chk("t1_b_char", 32'(got[1].ch), 32'h42);
      chk("t1_b_code", 32'(got[1].code), 32'h2);
      chk("t1_c_code", 32'(got[2].code), 32'h3);
    end

    // same tree, consumer stalls five cycles per codeword
    mode = 1;
    begin_run();
    do_start(1);
    wait_end(400);
    check_run();

    // single leaf root, then an empty root
    mode = 0;
    lmem[5] = 9'h041; rmem[5] = NUL;
    build_exp(5);
    begin_run();
    do_start(5);
    wait_end(200);
    check_run();
    lmem[6] = NUL; rmem[6] = NUL;
    build_exp(6);
    begin_run();
    do_start(6);
    wait_end(200);
    check_run();
    chk("empty_no_valid", 32'(rises), 32'h0);

    // 17 nested sums exceed the 16-bit code length
    for (int i = 10; i <= 27; i++) begin
      lmem[i] = 9'h100 | 9'(i + 1);
      rmem[i] = NUL;
    end
    begin_run();
    do_start(10);
    wait_end(500);
    chk("chain_error", 32'(error), 32'h1);
    chk("chain_done", 32'(done), 32'h0);
    chk("chain_emits", 32'(got.size()), 32'h0);
    chk("chain_reads", 32'(reads.size()), 32'd17);
    repeat (4) step();
    chk("chain_rd_req", 32'(bus.rd_req), 32'h0);
    chk("chain_err_hold", 32'(error), 32'h1);
    chk("chain_reads2", 32'(reads.size()), 32'd17);

    // en low in WAIT_RD swallows a read response
    build_exp(1);
    begin_run();
    sram_on = 0;
    do_start(1);
    step();
    en = 1'b0;
    bus.rd_valid = 1'b1;
    bus.rd_data = {lmem[1], rmem[1]};
    step();
    bus.rd_valid = 1'b0;
    repeat (3) step();
    chk("frz_rd_req", 32'(bus.rd_req), 32'h1);
    chk("frz_busy", 32'(busy), 32'h1);
    en = 1'b1;
    repeat (2) step();
    chk("frz_still_wait", 32'(bus.rd_req), 32'h1);
    chk("frz_no_valid", 32'(bus.cw_valid), 32'h0);
    sram_on = 1;
    req_prev = 1;
    rd_ai = 1;
    rd_cnt = 1;
    wait_end(300);
    check_run();

    // abort while a codeword is pending
    mode = 3;
    begin_run();
    do_start(1);
    wait_emit();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_cw_valid", 32'(bus.cw_valid), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);

    // reset while a codeword is pending
    begin_run();
    do_start(1);
    wait_emit();
    rst = 1'b0;
    step();
    check_zero("rst_emit");
    rst = 1'b1;

    // start held into FETCH has no effect
    mode = 0;
    begin_run();
    root_idx = 1;
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    wait_end(300);
    check_run();
    chk("restart_reads", 32'(reads.size()), 32'h2);

    // start from DONE begins a fresh count
    mode = 3;
    begin_run();
    do_start(1);
    chk("rerun_num", 32'(num_codes), 32'h0);
    chk("rerun_done", 32'(done), 32'h0);
    chk("rerun_busy", 32'(busy), 32'h1);
    abort = 1'b1;
    step();
    abort = 1'b0;

    // random trees with random consumer pacing
    for (int it = 0; it < 20; it++) begin
      gen_tree(r);
      build_exp(r);
      mode = $urandom_range(0, 2);
      begin_run();
      do_start(r);
      wait_end(3000);
      check_run();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, fails);
    $finish;
  end

endmodule
